// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator driven by a pixel clock-enable strobe.
// Optional colour-bar test pattern: define VGA_TIMING_PATTERN_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CW        = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    pix_r,
  input  logic [3:0]    pix_g,
  input  logic [3:0]    pix_b,
  output logic          pix_ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          Hsync,
  output logic          Vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [3:0]    vgaRed,
  output logic [3:0]    vgaGreen,
  output logic [3:0]    vgaBlue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_FP_POS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYN_POS = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_BP_POS  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_FP_POS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYN_POS = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_BP_POS  = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {StActive, StFront, StSync, StBack} axis_st_e;

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] x_d, y_d;
  logic          x_wrap;
  logic          adv;
  axis_st_e      h_st, h_st_d, v_st, v_st_d;

  assign adv = pix_ce & en;

  // Next coordinates and axis states; outputs are registered from these so they
  // always describe the (x,y) being displayed.
  always_comb begin
    x_wrap = (x == H_LAST);
    x_d    = x_wrap ? '0 : x + CW'(1);
    y_d    = y;
    if (x_wrap) begin
      y_d = (y == V_LAST) ? '0 : y + CW'(1);
    end

    h_st_d = h_st;
    case (h_st)
      StActive: if (x_d == H_FP_POS)  h_st_d = StFront;
      StFront:  if (x_d == H_SYN_POS) h_st_d = StSync;
      StSync:   if (x_d == H_BP_POS)  h_st_d = StBack;
      StBack:   if (x_d == '0)        h_st_d = StActive;
      default:                        h_st_d = StActive;
    endcase

    v_st_d = v_st;
    if (x_wrap) begin
      case (v_st)
        StActive: if (y_d == V_FP_POS)  v_st_d = StFront;
        StFront:  if (y_d == V_SYN_POS) v_st_d = StSync;
        StSync:   if (y_d == V_BP_POS)  v_st_d = StBack;
        StBack:   if (y_d == '0)        v_st_d = StActive;
        default:                        v_st_d = StActive;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      pix_ce      <= 1'b0;
      x           <= H_LAST;
      y           <= V_LAST;
      h_st        <= StBack;
      v_st        <= StBack;
      de          <= 1'b0;
      Hsync       <= ~HSYNC_POL;
      Vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (en) begin
        if (div_cnt == DIV_MAX) begin
          div_cnt <= '0;
          pix_ce  <= 1'b1;
        end else begin
          div_cnt <= div_cnt + DW'(1);
          pix_ce  <= 1'b0;
        end
      end else begin
        pix_ce <= 1'b0;
      end

      if (adv) begin
        x           <= x_d;
        y           <= y_d;
        h_st        <= h_st_d;
        v_st        <= v_st_d;
        de          <= (h_st_d == StActive) && (v_st_d == StActive);
        Hsync       <= (h_st_d == StSync) ? HSYNC_POL : ~HSYNC_POL;
        Vsync       <= (v_st_d == StSync) ? VSYNC_POL : ~VSYNC_POL;
        line_start  <= (x_d == '0);
        frame_start <= (x_d == '0) && (y_d == '0);
      end else begin
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

`ifdef VGA_TIMING_PATTERN_EN
  localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

  logic [2:0]    bar_idx;
  logic [CW-1:0] bar_cnt;
  logic          unused_pix;

  assign unused_pix = ^{pix_r, pix_g, pix_b};

  // Bar index tracks x_d so it lines up with the registered coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_idx <= '0;
      bar_cnt <= '0;
    end else if (adv) begin
      if (x_d == '0) begin
        bar_idx <= '0;
        bar_cnt <= '0;
      end else if (x_d < H_FP_POS) begin
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + CW'(1);
        end
      end
    end
  end

  assign vgaRed   = (de && bar_idx[2]) ? 4'hF : 4'h0;
  assign vgaGreen = (de && bar_idx[1]) ? 4'hF : 4'h0;
  assign vgaBlue  = (de && bar_idx[0]) ? 4'hF : 4'h0;
`else
  assign vgaRed   = de ? pix_r : 4'h0;
  assign vgaGreen = de ? pix_g : 4'h0;
  assign vgaBlue  = de ? pix_b : 4'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 640x480 instance plus a tiny
// active-high-sync instance with CLK_DIV=1 for full-frame checks.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  pix_r, pix_g, pix_b;

  logic        pce0, de0, hs0, vs0, ls0, fs0;
  logic [11:0] x0, y0;
  logic [3:0]  r0, g0, b0;

  logic        pce1, de1, hs1, vs1, ls1, fs1;
  logic [11:0] x1, y1;
  logic [3:0]  r1, g1, b1;

  int checks   = 0;
  int failures = 0;

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_ce(pce0), .x(x0), .y(y0), .de(de0), .Hsync(hs0), .Vsync(vs0),
    .line_start(ls0), .frame_start(fs0), .vgaRed(r0), .vgaGreen(g0), .vgaBlue(b0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(12)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_ce(pce1), .x(x1), .y(y1), .de(de1), .Hsync(hs1), .Vsync(vs1),
    .line_start(ls1), .frame_start(fs1), .vgaRed(r1), .vgaGreen(g1), .vgaBlue(b1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x;
    logic de;
    logic hs;
  } hvec_t;

  hvec_t hv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int xx, input logic de_e);
`ifdef VGA_TIMING_PATTERN_EN
    int idx;
    idx = xx / 80;
    if (!de_e) return 12'h000;
    return {(idx[2] ? 4'hF : 4'h0), (idx[1] ? 4'hF : 4'h0), (idx[0] ? 4'hF : 4'h0)};
`else
    return de_e ? {pix_r, pix_g, pix_b} : 12'h000;
`endif
  endfunction

  task automatic wait_x(input int v);
    int n;
    n = 0;
    while (32'(x0) != v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_x", 32'(x0), 32'(v));
  endtask

  task automatic check_reset();
    chk("rst_x0", 32'(x0), 32'd799);
    chk("rst_y0", 32'(y0), 32'd524);
    chk("rst_de0", 32'(de0), 32'd0);
    chk("rst_hs0", 32'(hs0), 32'd1);
    chk("rst_vs0", 32'(vs0), 32'd1);
    chk("rst_pce0", 32'(pce0), 32'd0);
    chk("rst_ls0", 32'(ls0), 32'd0);
    chk("rst_fs0", 32'(fs0), 32'd0);
    chk("rst_rgb0", 32'({r0, g0, b0}), 32'd0);
    chk("rst_x1", 32'(x1), 32'd13);
    chk("rst_y1", 32'(y1), 32'd6);
    chk("rst_hs1", 32'(hs1), 32'd0);
    chk("rst_vs1", 32'(vs1), 32'd0);
  endtask

  // Called right after rst falls at a negedge; cycle c is sampled after edge c.
  task automatic check_startup();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("startup_pix_ce", 32'(pce0), 32'(c % 4 == 0));
      chk("startup_frame_start", 32'(fs0), 32'(c == 5));
      if (c == 5) begin
        chk("startup_x", 32'(x0), 32'd0);
        chk("startup_y", 32'(y0), 32'd0);
      end
    end
  endtask

  initial begin
    int n;
    int p, mx, my;

    hv[0]  = '{0,   1'b1, 1'b1};
    hv[1]  = '{1,   1'b1, 1'b1};
    hv[2]  = '{79,  1'b1, 1'b1};
    hv[3]  = '{80,  1'b1, 1'b1};
    hv[4]  = '{159, 1'b1, 1'b1};
    hv[5]  = '{560, 1'b1, 1'b1};
    hv[6]  = '{639, 1'b1, 1'b1};
    hv[7]  = '{640, 1'b0, 1'b1};
    hv[8]  = '{655, 1'b0, 1'b1};
    hv[9]  = '{656, 1'b0, 1'b0};
    hv[10] = '{751, 1'b0, 1'b0};
    hv[11] = '{752, 1'b0, 1'b1};
    hv[12] = '{799, 1'b0, 1'b1};

    clk   = 1'b0;
    rst   = 1'b1;
    en    = 1'b1;
    pix_r = 4'hA;
    pix_g = 4'h5;
    pix_b = 4'h3;

    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    check_startup();

    // First line of the default raster.
    for (int i = 0; i < 13; i++) begin
      wait_x(hv[i].x);
      chk("h_de", 32'(de0), 32'(hv[i].de));
      chk("h_hsync", 32'(hs0), 32'(hv[i].hs));
      chk("h_rgb", 32'({r0, g0, b0}), 32'(exp_rgb(hv[i].x, hv[i].de)));
    end

    // pix_ce period.
    n = 0;
    while (!pce0 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!pce0 && n < 20);
    chk("pix_ce_period", 32'(n), 32'd4);

    // line_start period.
    n = 0;
    while (!ls0 && n < 5000) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!ls0 && n < 5000);
    chk("line_start_period", 32'(n), 32'd3200);

    // Enable freeze at x=300 and resume.
    wait_x(300);
    en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("en_hold_x", 32'(x0), 32'd300);
      chk("en_no_pix_ce", 32'(pce0), 32'd0);
    end
    en = 1'b1;
    n = 0;
    while (32'(x0) != 32'd301 && n < 50) begin @(negedge clk); n++; end
    chk("en_resume_cycles", 32'(n), 32'd4);

    // A pulse already high is cleared when en drops.
    n = 0;
    while (!ls0 && n < 5000) begin @(negedge clk); n++; end
    chk("pulse_seen", 32'(ls0), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("en_pulse_clear", 32'(ls0), 32'd0);
    chk("en_pulse_hold_x", 32'(x0), 32'd0);
    en = 1'b1;

    // Mid-frame asynchronous reset, then a clean restart.
    wait_x(300);
    rst = 1'b1;
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    check_startup();

    // Tiny raster: two full frames against an independent position model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      chk("s_pix_ce", 32'(pce1), 32'd1);
      if (c >= 2) begin
        p  = c - 2;
        mx = p % 14;
        my = (p / 14) % 7;
        chk("s_x", 32'(x1), 32'(mx));
        chk("s_y", 32'(y1), 32'(my));
        chk("s_de", 32'(de1), 32'(mx < 8 && my < 4));
        chk("s_hsync", 32'(hs1), 32'(mx >= 10 && mx <= 11));
        chk("s_vsync", 32'(vs1), 32'(my == 5));
        chk("s_line_start", 32'(ls1), 32'(mx == 0));
        chk("s_frame_start", 32'(fs1), 32'(mx == 0 && my == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 sync generator and its divide-by-4 pixel clock. It runs in the system `clk` domain and produces a pixel clock-enable strobe instead of a derived clock. It provides programmable porch, pulse and active widths per axis, selectable sync polarity, pixel coordinates, frame and line start pulses, and gated colour outputs. It sits between the board clock and the VGA connector pins. Pixel-source logic reads `x`/`y` and drives colour.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 4, `clk` cycles per pixel, ≥1
- HSYNC_POL, 0, 0 = active-low Hsync, 1 = active-high
- VSYNC_POL, 0, same for Vsync
- CW, 12, coordinate width; 2^CW ≥ max(H_TOTAL, V_TOTAL)

Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance enable; low freezes all timing state
- pix_r, pix_g, pix_b  in  4 each  colour for the current (x,y)
- pix_ce  out  1  one-`clk` pixel strobe
- x, y  out  CW each  current column/line, counting through blanking
- de  out  1  high in active area
- Hsync, Vsync  out  1 each  sync outputs at configured polarity
- line_start, frame_start  out  1 each  one-pixel pulses
- vgaRed, vgaGreen, vgaBlue  out  4 each  colour to DAC

## Operation
- Divider: `div_cnt` runs 0..CLK_DIV-1 while `en` is high. `pix_ce` is registered and is high in clk cycles k*CLK_DIV after reset release (k ≥ 1). With CLK_DIV=1, `pix_ce` is high every cycle.
- On each rising edge with `pix_ce`=1, counters advance:
  - `x` increments.
  - `x` wraps from H_TOTAL-1 to 0 and increments `y` at the wrap.
  - `y` wraps from V_TOTAL-1 to 0.
- Per-axis state machine with states ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Horizontal boundaries: x = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, 0.
  - The vertical machine steps only on `x` wrap, with boundaries on `y`.
- `de`, `Hsync`, `Vsync`, `line_start`, `frame_start` are registered on the same edge as `x`/`y`, so they always describe the displayed (x,y):
  - `de` = both axes in ACTIVE.
  - A sync output is at its asserted level only in SYNC.
  - `line_start` = (x==0).
  - `frame_start` = (x==0 && y==0).
  - `line_start` and `frame_start` are cleared on the next clk edge, so each is a single `clk` cycle wide.
- Colour without the macro (see Configuration): `vgaRed` = `de` ? `pix_r` : 0 (combinational). Green and blue follow the same rule.
- `en` low:
  - `div_cnt`, counters and all registered outputs hold.
  - `pix_ce` is 0 from the next edge.
  - Pulses already high are cleared.
- Reset values, applied immediately (asynchronous):
  - div_cnt=0, pix_ce=0.
  - x=H_TOTAL-1, y=V_TOTAL-1, so the first pixel strobe moves to (0,0) and pulses `frame_start`.
  - de=0, line_start=0, frame_start=0.
  - Hsync=!HSYNC_POL, Vsync=!VSYNC_POL.
  - Colour outputs 0.
- Reset mid-frame aborts the frame. The restart begins cleanly at (0,0).

## Timing
- Outputs change only on `pix_ce` edges. Latency from counter update to sync/de update is 0.
- Line period: H_TOTAL*CLK_DIV clk. Frame period: H_TOTAL*V_TOTAL*CLK_DIV clk (1,680,000 at defaults).
- First `frame_start` occurs in cycle CLK_DIV+1 after reset release with `en` high.

## Configuration
- `VGA_TIMING_PATTERN_EN` defined:
  - `pix_*` inputs are ignored.
  - A registered 8-bar generator advances a 3-bit bar index every H_ACTIVE/8 active pixels; H_ACTIVE must be divisible by 8.
  - The bar index resets to 0 at x==0.
  - Red = 15 if bit2 of the index is set, green = 15 if bit1, blue = 15 if bit0; 0 otherwise.
  - Colour is forced to 0 outside `de`.
- Macro undefined: no bar logic; colour follows the combinational `pix_*` gating above.

## Test plan
- Reset: assert `rst` at x=300 → all outputs at reset values within the same cycle. Release → `frame_start` at cycle 5 (CLK_DIV=4) with x=0, y=0.
- Horizontal, defaults:
  - `pix_ce` period 4 clk.
  - `de` high for x 0..639.
  - Hsync=0 exactly for x 656..751.
  - `line_start` every 3200 clk.
- Vertical, defaults:
  - Vsync=0 for y 490..491.
  - `de`=0 for y ≥ 480.
  - `frame_start` once per 420,000 `pix_ce`.
- Enable: drop `en` for 100 clk at x=300 → x stays 300, no `pix_ce`. Resume → x=301 after CLK_DIV cycles.
- Polarity and small timing: HSYNC_POL=1, VSYNC_POL=1, CLK_DIV=1, H=8/2/2/2, V=4/1/1/1 → Hsync=1 only at x 10..11, Vsync=1 only at y 5, `pix_ce` constant 1.
- Colour:
  - Without macro, pix_r=4'hA → vgaRed=4'hA for x<640, 0 in blanking.
  - With macro: x 0..79 → colour 0/0/0; x 80..159 → blue 15; x 560..639 → 15/15/15; x ≥ 640 → 0.
